// File: rtl/wb_commit_checker.sv
// wb_commit_checker: end-of-test checker that watches the writeback/retire
// stream of the execution unit.
//  - A shadow copy of the architectural register file is built from the RF
//    write port.
//  - A table of up to NUM_CHK (pc, reg, value) checkpoints is evaluated in
//    order while the checker is in RUN.
//  - The verdict (pass, mismatch, timeout, hang) is reported on registered
//    status outputs.
// Optional feature: define CHK_HANG_DETECT_EN to enable self-loop hang
// detection (HANG_N consecutive retires of the same PC).
// The FSM state is visible on state_dbg for checkers and waveforms.
module wb_commit_checker #(
    parameter int NUM_CHK = 4,
    parameter int PC_W    = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 100000,
    parameter int HANG_N  = 16,
    localparam int IDX_W  = (NUM_CHK > 1) ? $clog2(NUM_CHK) : 1,
    localparam int NUM_W  = $clog2(NUM_CHK) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [PC_W-1:0]   cfg_pc,
    input  logic [4:0]        cfg_reg,
    input  logic [DATA_W-1:0] cfg_val,
    input  logic [NUM_W-1:0]  cfg_num,
    input  logic              start,
    input  logic              ret_valid,
    input  logic [PC_W-1:0]   ret_pc,
    input  logic              rf_wen,
    input  logic [4:0]        rf_waddr,
    input  logic [DATA_W-1:0] rf_wdata,
    output logic              done,
    output logic              pass,
    output logic [1:0]        fail_code,
    output logic [IDX_W-1:0]  fail_idx,
    output logic [31:0]       cyc_cnt,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } state_t;

    localparam logic [1:0] FC_NONE     = 2'd0;
    localparam logic [1:0] FC_MISMATCH = 2'd1;
    localparam logic [1:0] FC_TIMEOUT  = 2'd2;
    localparam logic [1:0] FC_HANG     = 2'd3;

    state_t              state_q;
    logic [IDX_W-1:0]    ptr_q;
    logic [NUM_W-1:0]    num_q;
    logic                done_q;
    logic                pass_q;
    logic [1:0]          fail_code_q;
    logic [IDX_W-1:0]    fail_idx_q;
    logic [31:0]         cyc_cnt_q;

    logic [DATA_W-1:0]   shadow_q  [32];
    logic [PC_W-1:0]     tbl_pc_q  [NUM_CHK];
    logic [4:0]          tbl_reg_q [NUM_CHK];
    logic [DATA_W-1:0]   tbl_val_q [NUM_CHK];

    logic [PC_W-1:0]     cur_pc;
    logic [4:0]          cur_reg;
    logic [DATA_W-1:0]   cur_val;
    logic [DATA_W-1:0]   cmp_val;
    logic                hit;
    logic                match;
    logic                last_entry;
    logic [31:0]         cyc_d;
    logic                timeout_hit;
    logic                hang_trip;
    logic [NUM_W-1:0]    num_d;

    assign done      = done_q;
    assign pass      = pass_q;
    assign fail_code = fail_code_q;
    assign fail_idx  = fail_idx_q;
    assign cyc_cnt   = cyc_cnt_q;
    assign state_dbg = state_q;

    // Current checkpoint lookup, same-cycle RF forwarding and status predicates.
    always_comb begin
        cur_pc      = tbl_pc_q[ptr_q];
        cur_reg     = tbl_reg_q[ptr_q];
        cur_val     = tbl_val_q[ptr_q];
        // A write to the checked register in the retire cycle is the value
        // the retiring instruction produced, so it overrides the shadow copy.
        if (rf_wen && (rf_waddr == cur_reg) && (cur_reg != 5'd0)) begin
            cmp_val = rf_wdata;
        end else begin
            cmp_val = shadow_q[cur_reg];
        end
        hit         = ret_valid && (ret_pc == cur_pc);
        match       = (cmp_val == cur_val);
        last_entry  = (int'(ptr_q) == (int'(num_q) - 1));
        cyc_d       = (cyc_cnt_q == 32'hFFFF_FFFF) ? cyc_cnt_q : cyc_cnt_q + 32'd1;
        timeout_hit = (cyc_d == 32'(TIMEOUT));
        // More active entries than the table holds are clamped to the table size.
        if (int'(cfg_num) > NUM_CHK) begin
            num_d = NUM_W'(NUM_CHK);
        end else begin
            num_d = cfg_num;
        end
    end

`ifdef CHK_HANG_DETECT_EN
    localparam int HANG_W = $clog2(HANG_N + 1);

    logic [HANG_W-1:0] hang_q;
    logic [HANG_W-1:0] hang_d;
    logic [PC_W-1:0]   last_pc_q;

    // Next value of the consecutive-same-PC retire counter (saturating).
    always_comb begin
        hang_d = hang_q;
        if (ret_valid) begin
            if ((hang_q != '0) && (ret_pc == last_pc_q)) begin
                if (hang_q != HANG_W'(HANG_N)) begin
                    hang_d = hang_q + 1'b1;
                end
            end else begin
                hang_d = HANG_W'(1);
            end
        end
        hang_trip = ret_valid && (hang_d == HANG_W'(HANG_N));
    end

    // Self-loop tracking runs only in RUN; idle retire cycles keep the count.
    always_ff @(posedge clk) begin
        if (reset || (state_q != ST_RUN)) begin
            hang_q    <= '0;
            last_pc_q <= '0;
        end else begin
            hang_q <= hang_d;
            if (ret_valid) begin
                last_pc_q <= ret_pc;
            end
        end
    end
`else
    logic hang_unused;
    assign hang_unused = (HANG_N > 0);
    assign hang_trip   = 1'b0;
`endif

    // Shadow register file: mirrors every RF write in all states; r0 stays 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                shadow_q[i] <= '0;
            end
        end else if (rf_wen && (rf_waddr != 5'd0)) begin
            shadow_q[rf_waddr] <= rf_wdata;
        end
    end

    // Checkpoint table: writable only while not running.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CHK; i++) begin
                tbl_pc_q[i]  <= '0;
                tbl_reg_q[i] <= '0;
                tbl_val_q[i] <= '0;
            end
        end else if (cfg_we && (state_q != ST_RUN) && (int'(cfg_idx) < NUM_CHK)) begin
            tbl_pc_q[cfg_idx]  <= cfg_pc;
            tbl_reg_q[cfg_idx] <= cfg_reg;
            tbl_val_q[cfg_idx] <= cfg_val;
        end
    end

    // Checker FSM with registered status; checkpoint result beats hang beats timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            num_q       <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_code_q <= FC_NONE;
            fail_idx_q  <= '0;
            cyc_cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    cyc_cnt_q <= cyc_d;
                    if (hit) begin
                        if (match) begin
                            if (last_entry) begin
                                state_q <= ST_PASS;
                                done_q  <= 1'b1;
                                pass_q  <= 1'b1;
                            end else begin
                                ptr_q <= ptr_q + 1'b1;
                            end
                        end else begin
                            state_q     <= ST_FAIL;
                            done_q      <= 1'b1;
                            fail_code_q <= FC_MISMATCH;
                            fail_idx_q  <= ptr_q;
                        end
                    end else if (hang_trip) begin
                        state_q     <= ST_FAIL;
                        done_q      <= 1'b1;
                        fail_code_q <= FC_HANG;
                    end else if (timeout_hit) begin
                        state_q     <= ST_FAIL;
                        done_q      <= 1'b1;
                        fail_code_q <= FC_TIMEOUT;
                    end
                end
                default: begin
                    // IDLE, PASS and FAIL all arm the checker on start.
                    if (start) begin
                        ptr_q       <= '0;
                        num_q       <= num_d;
                        cyc_cnt_q   <= '0;
                        fail_code_q <= FC_NONE;
                        fail_idx_q  <= '0;
                        if (cfg_num == '0) begin
                            state_q <= ST_PASS;
                            done_q  <= 1'b1;
                            pass_q  <= 1'b1;
                        end else begin
                            state_q <= ST_RUN;
                            done_q  <= 1'b0;
                            pass_q  <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

endmodule
